// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response bundle between requesters and the ALU share arbiter
//
// Purpose: groups the per-requester request bus (packed NUM_REQ-wide) and the
// single tagged response channel.
// Ports (signals):
//   req_valid/req_ready      NUM_REQ         request handshake, ready is one-hot
//   req_control              NUM_REQ*4       ALU opcode per requester
//   req_imm_en               NUM_REQ*2       operand-2 select per requester
//   req_in_1/req_in_2        NUM_REQ*WORD    register operands
//   req_imm / req_imm_U_J    NUM_REQ*12/20   immediates
//   rsp_valid/rsp_ready      1               response handshake
//   rsp_id                   ID_W            owning requester
//   rsp_data                 WORD            ALU result
//   rsp_take_branch          1               ALU branch decision
// Modports: master = requesters/consumer side, slave = arbiter side.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int WORD_SIZE = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*4-1:0]         req_control;
    logic [NUM_REQ*2-1:0]         req_imm_en;
    logic [NUM_REQ*WORD_SIZE-1:0] req_in_1;
    logic [NUM_REQ*WORD_SIZE-1:0] req_in_2;
    logic [NUM_REQ*12-1:0]        req_imm;
    logic [NUM_REQ*20-1:0]        req_imm_U_J;

    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [ID_W-1:0]              rsp_id;
    logic [WORD_SIZE-1:0]         rsp_data;
    logic                         rsp_take_branch;

    modport master (
        output req_valid, req_control, req_imm_en, req_in_1, req_in_2,
               req_imm, req_imm_U_J, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_take_branch
    );

    modport slave (
        input  req_valid, req_control, req_imm_en, req_in_1, req_in_2,
               req_imm, req_imm_U_J, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_take_branch
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one registered ALU among NUM_REQ requesters
//
// Purpose: picks one requester round-robin, latches its operands, drives them
// into the registered ALU for one cycle, then returns the ALU result tagged
// with the requester index. One operation in flight at a time.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   bus (slave)           request bus and tagged response channel
//   alu_control..alu_imm_U_J   operand registers driving the ALU inputs
//   alu_out, alu_take_branch   ALU results, passed through to the response
//   busy                  state is not IDLE
//   issue_cnt             accepted-request count, wraps silently
module alu_share_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int WORD_SIZE = 32,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_share_arbiter_if.slave   bus,
    output logic [3:0]           alu_control,
    output logic [1:0]           alu_imm_en,
    output logic [WORD_SIZE-1:0] alu_in_1,
    output logic [WORD_SIZE-1:0] alu_in_2,
    output logic [11:0]          alu_imm,
    output logic [19:0]          alu_imm_U_J,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_take_branch,
    output logic                 busy,
    output logic [CNT_W-1:0]     issue_cnt
);
    localparam logic [3:0] ALU_ADD_I    = 4'd0;
    localparam logic [1:0] ALU_READ_RS2 = 2'd0;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;

    logic            arb_en;
    logic            found;
    logic            handshake;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    logic [ID_W-1:0] next_ptr;

    logic [3:0]           sel_control;
    logic [1:0]           sel_imm_en;
    logic [WORD_SIZE-1:0] sel_in_1;
    logic [WORD_SIZE-1:0] sel_in_2;
    logic [11:0]          sel_imm;
    logic [19:0]          sel_imm_U_J;

    // Arbitration is open in IDLE, and in WB only once the response is taken,
    // so a new op can be granted in the same cycle the previous one retires.
    assign arb_en    = (state == IDLE) || ((state == WB) && bus.rsp_ready);
    assign handshake = arb_en && found;

    // Search upward from rr_ptr with wrap; one extra bit absorbs the carry
    // before folding back into range (NUM_REQ need not be a power of two).
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_control = '0;
        sel_imm_en  = '0;
        sel_in_1    = '0;
        sel_in_2    = '0;
        sel_imm     = '0;
        sel_imm_U_J = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_control = bus.req_control[i*4 +: 4];
                sel_imm_en  = bus.req_imm_en[i*2 +: 2];
                sel_in_1    = bus.req_in_1[i*WORD_SIZE +: WORD_SIZE];
                sel_in_2    = bus.req_in_2[i*WORD_SIZE +: WORD_SIZE];
                sel_imm     = bus.req_imm[i*12 +: 12];
                sel_imm_U_J = bus.req_imm_U_J[i*20 +: 20];
            end
        end
    end

    assign next_ptr = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

    assign bus.req_ready = handshake ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            id_q        <= '0;
            issue_cnt   <= '0;
            alu_control <= ALU_ADD_I;
            alu_imm_en  <= ALU_READ_RS2;
            alu_in_1    <= '0;
            alu_in_2    <= '0;
            alu_imm     <= '0;
            alu_imm_U_J <= '0;
        end else begin
            if (handshake) begin
                state       <= EXEC;
                rr_ptr      <= next_ptr;
                id_q        <= grant_idx;
                issue_cnt   <= issue_cnt + CNT_W'(1);
                alu_control <= sel_control;
                alu_imm_en  <= sel_imm_en;
                alu_in_1    <= sel_in_1;
                alu_in_2    <= sel_in_2;
                alu_imm     <= sel_imm;
                alu_imm_U_J <= sel_imm_U_J;
            end else if (state == EXEC) begin
                state <= WB;
            end else if ((state == WB) && bus.rsp_ready) begin
                state <= IDLE;
            end
        end
    end

    // Operand registers stay put through WB, so the registered ALU keeps
    // recomputing the same result and rsp_data is stable under backpressure.
    assign bus.rsp_valid       = (state == WB);
    assign bus.rsp_id          = id_q;
    assign bus.rsp_data        = alu_out;
    assign bus.rsp_take_branch = alu_take_branch;
    assign busy                = (state != IDLE);
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single registered ALU among NUM_REQ requesters, e.g. the main pipeline and a branch/address helper.
- Round-robin arbitration with a valid/ready handshake on both the request and response sides.
- Latches the winning operands, sequences them into the ALU, and returns the result tagged with the requester ID.
- Sits between the requesters and the ALU instance; it owns every ALU input and consumes the ALU result and branch flag.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WORD_SIZE, 32, operand/result width.
- ID_W, $clog2(NUM_REQ), requester ID width (derived; do not override).
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; a handshake occurs when valid and ready are both high
- req_control  in  NUM_REQ*4  per-requester ALU opcode (constants.svh encodings)
- req_imm_en  in  NUM_REQ*2  per-requester operand-2 select
- req_in_1, req_in_2  in  NUM_REQ*WORD_SIZE  register operands
- req_imm  in  NUM_REQ*12  I-type immediate
- req_imm_U_J  in  NUM_REQ*20  U/J immediate
- alu_control  out  4  to ALU control
- alu_imm_en  out  2  to ALU imm_en
- alu_in_1, alu_in_2  out  WORD_SIZE  to ALU
- alu_imm  out  12  to ALU
- alu_imm_U_J  out  20  to ALU
- alu_out  in  WORD_SIZE  from ALU
- alu_take_branch  in  1  from ALU
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_id  out  ID_W  requester that owns the result
- rsp_data  out  WORD_SIZE  ALU result
- rsp_take_branch  out  1  ALU branch decision
- busy  out  1  high when state is not IDLE
- issue_cnt  out  CNT_W  number of accepted requests; wraps at 2^CNT_W

Behaviour:
- Reset:
  - state=IDLE; rr pointer=0; operand registers=0 (alu_control=ALU_ADD_I encoding, alu_imm_en=ALU_READ_RS2).
  - req_ready=0, rsp_valid=0, rsp_id=0, busy=0, issue_cnt=0.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - req_ready is one-hot to the first valid requester found searching upward from the rr pointer, with wrap-around.
  - On a handshake, that requester's fields are latched into the operand registers, its index into id_q, and issue_cnt increments; next state is EXEC.
  - With no valid requests, stay in IDLE and drive req_ready=0.
- EXEC:
  - Operand registers drive the ALU; the ALU captures them at the end of this cycle.
  - req_ready=0; go to WB.
- WB:
  - rsp_valid=1; rsp_data=alu_out and rsp_take_branch=alu_take_branch, both passed through combinationally; rsp_id=id_q.
  - Operand registers are held, so the ALU recomputes the same value and the result stays stable while stalled.
  - If rsp_ready=0: stay in WB, req_ready=0.
  - If rsp_ready=1: the response completes. In the same cycle arbitration runs as in IDLE. A new grant latches new operands and goes to EXEC; otherwise go to IDLE.
- Latency and throughput:
  - Handshake in cycle t gives rsp_valid in cycle t+2.
  - Peak throughput is one op per 2 cycles; only one op is in flight at a time.
- Round-robin: after a grant to index g, the rr pointer becomes (g+1) mod NUM_REQ. The pointer does not change when there is no grant.
- A requester must hold its fields stable only during its handshake cycle. Deasserting req_valid without a handshake is legal.
- Branch-class ops return rsp_data=0 (the ALU drives 0). Non-branch ops return rsp_take_branch=0.
- Unknown control codes are forwarded unchanged; rsp_data then reflects the ALU's held output, and the consumer is responsible for it.
- Reset asserted in EXEC or WB: the in-flight op is discarded with no response, and the ALU is reset by the same reset.
- issue_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Single op: only req0 valid with ALU_ADD_I, imm_en=ALU_READ_IMM, in_1=5, imm=12'd7 -> req_ready=2'b01 in cycle t; rsp_valid at t+2 with rsp_data=12, rsp_id=0, rsp_take_branch=0; issue_cnt=1.
- Round-robin: req0 and req1 held valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 every 2 cycles; rsp_id sequence 0,1,0,1.
- Backpressure: req1 ALU_SUB_I 10-3 with rsp_ready=0 for 4 cycles -> rsp_valid held, rsp_data=7 stable, req_ready=0 throughout; accepted on the cycle rsp_ready=1, then return to IDLE.
- Branch: req0 ALU_BLT with in_1=-1, in_2=1, imm_en=ALU_READ_RS2 -> rsp_take_branch=1, rsp_data=0. Then ALU_BGE_U with in_1=0xFFFFFFFF, in_2=1 -> rsp_take_branch=1.
- Reset mid-op: assert reset during EXEC -> next cycle busy=0, rsp_valid=0, issue_cnt=0, no response ever issued for that op.
- Counter wrap: force 65536 accepted ops (CNT_W=16) -> issue_cnt reads 0.
